// File: rtl/sampling_layer_generic.sv
// 2x2 stride-2 max/average pooling over CHANNELS parallel raster feature maps.
// Define SAMPLING_RELU_EN to clamp negative pooled values to zero.
module sampling_layer_generic #(
   parameter int CHANNELS  = 6,
   parameter int DATA_W    = 32,
   parameter int IMG_W     = 24,
   parameter int IMG_H     = 24,
   parameter int POOL_MODE = 0
) (
   input  logic                       Clock,
   input  logic                       Input_Reset,
   input  logic                       Input_Valid,
   input  logic                       Input_Finish,
   input  logic [CHANNELS*DATA_W-1:0] Input_Pixel,
   output logic [CHANNELS*DATA_W-1:0] Output_Pixel,
   output logic                       Output_Valid,
   output logic                       Output_Finish
);

   localparam int HW = DATA_W + 1;
   localparam int SW = DATA_W + 2;
   localparam int LD = IMG_W / 2;
   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int LW = (LD > 1) ? $clog2(LD) : 1;

   typedef logic signed [DATA_W-1:0] pix_t;
   typedef logic signed [HW-1:0]     pair_t;

   logic [CW-1:0]                col_q;
   logic [RW-1:0]                row_q;
   logic                         s_vld_q;
   logic [CHANNELS*DATA_W-1:0]   s_pix_q;
   logic [CW-1:0]                s_col_q;
   logic [RW-1:0]                s_row_q;
   pix_t                         hold_q [CHANNELS];
   pair_t                        lb_q   [CHANNELS][LD];
   pix_t                         out_q  [CHANNELS];
   logic                         ovld_q;
   logic                         ofin_q;
   pair_t                        h_w    [CHANNELS];
   pix_t                         pool_w [CHANNELS];

   logic          accept;
   logic          col_last;
   logic          row_last;
   logic          kill;
   logic          proc;
   logic          s_odd_c;
   logic          s_odd_r;
   logic          s_last;
   logic [LW-1:0] lb_idx;

   assign accept   = Input_Valid & ~Input_Finish;
   assign col_last = (col_q == CW'(IMG_W - 1));
   assign row_last = (row_q == RW'(IMG_H - 1));
   // An abort mid-frame also cancels the pixel still sitting in the stage.
   assign kill     = Input_Finish & ((|col_q) | (|row_q));
   assign proc     = s_vld_q & ~kill;
   assign s_odd_c  = s_col_q[0];
   assign s_odd_r  = s_row_q[0];
   assign s_last   = (s_col_q == CW'(IMG_W - 1)) &
                     (s_row_q == RW'(IMG_H - 1));
   assign lb_idx   = LW'(s_col_q >> 1);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pix_t  a;
      pix_t  b;
      pair_t pair;
      pair_t prev;
      pix_t  pooled;

      assign a    = hold_q[g];
      assign b    = s_pix_q[g*DATA_W +: DATA_W];
      assign prev = lb_q[g][lb_idx];

      if (POOL_MODE == 0) begin : g_max
         assign pair   = (a >= b) ? HW'(a) : HW'(b);
         assign pooled = (pair >= prev) ? DATA_W'(pair)
                                        : DATA_W'(prev);
      end else begin : g_avg
         logic signed [SW-1:0] sum4;
         assign pair   = HW'(a) + HW'(b);
         assign sum4   = SW'(pair) + SW'(prev);
         assign pooled = DATA_W'(sum4 >>> 2);
      end

`ifdef SAMPLING_RELU_EN
      assign pool_w[g] = pooled[DATA_W-1] ? '0 : pooled;
`else
      assign pool_w[g] = pooled;
`endif
      assign h_w[g] = pair;
      assign Output_Pixel[g*DATA_W +: DATA_W] = out_q[g];
   end

   always_ff @(posedge Clock or negedge Input_Reset) begin
      if (!Input_Reset) begin
         col_q   <= '0;
         row_q   <= '0;
         s_vld_q <= 1'b0;
         s_pix_q <= '0;
         s_col_q <= '0;
         s_row_q <= '0;
      end else begin
         s_vld_q <= accept;
         if (Input_Finish) begin
            col_q <= '0;
            row_q <= '0;
         end else if (Input_Valid) begin
            s_pix_q <= Input_Pixel;
            s_col_q <= col_q;
            s_row_q <= row_q;
            if (col_last) begin
               col_q <= '0;
               row_q <= row_last ? '0 : row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Input_Reset) begin
      if (!Input_Reset) begin
         ovld_q <= 1'b0;
         ofin_q <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            hold_q[c] <= '0;
            out_q[c]  <= '0;
         end
      end else begin
         ovld_q <= proc & s_odd_c & s_odd_r;
         ofin_q <= proc & s_odd_c & s_odd_r & s_last;
         for (int c = 0; c < CHANNELS; c++) begin
            if (proc & ~s_odd_c)
               hold_q[c] <= s_pix_q[c*DATA_W +: DATA_W];
            if (proc & s_odd_c & s_odd_r)
               out_q[c] <= pool_w[c];
         end
      end
   end

   // Line buffer carries no reset; entries are always written before use.
   always_ff @(posedge Clock) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (proc & s_odd_c & ~s_odd_r)
            lb_q[c][lb_idx] <= h_w[c];
      end
   end

   assign Output_Valid  = ovld_q;
   assign Output_Finish = ofin_q;

endmodule

// File: tb/tb_sampling_layer_generic.sv
// Scoreboard bench for sampling_layer_generic: max and average
// instances share one stimulus stream and one reference model.
module tb_sampling_layer_generic;

   localparam int C  = 2;
   localparam int W  = 16;
   localparam int IW = 4;
   localparam int IH = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           vld;
   logic           fin;
   logic [C*W-1:0] pix;
   logic [C*W-1:0] om;
   logic [C*W-1:0] oa;
   logic           vm;
   logic           va;
   logic           fm;
   logic           fa;

   sampling_layer_generic #(
      .CHANNELS(C), .DATA_W(W), .IMG_W(IW), .IMG_H(IH), .POOL_MODE(0)
   ) u_max (
      .Clock(clk), .Input_Reset(rst_n), .Input_Valid(vld),
      .Input_Finish(fin), .Input_Pixel(pix), .Output_Pixel(om),
      .Output_Valid(vm), .Output_Finish(fm)
   );

   sampling_layer_generic #(
      .CHANNELS(C), .DATA_W(W), .IMG_W(IW), .IMG_H(IH), .POOL_MODE(1)
   ) u_avg (
      .Clock(clk), .Input_Reset(rst_n), .Input_Valid(vld),
      .Input_Finish(fin), .Input_Pixel(pix), .Output_Pixel(oa),
      .Output_Valid(va), .Output_Finish(fa)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [C*W-1:0] px;
      logic           f;
      int             t;
   } exp_t;

   exp_t qm[$];
   exp_t qa[$];
   int   npass = 0;
   int   ntot  = 0;
   int   nvm   = 0;
   int   nfm   = 0;
   int   nva   = 0;
   int   nfa   = 0;
   int   fr[C][IH][IW];
   int   mrow  = 0;
   int   mcol  = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [C*W-1:0] expv(input bit avg, input int r,
                                           input int c);
      logic [C*W-1:0] res;
      res = '0;
      for (int ch = 0; ch < C; ch++) begin
         int a;
         int b;
         int d;
         int e;
         int v;
         a = fr[ch][r-1][c-1];
         b = fr[ch][r-1][c];
         d = fr[ch][r][c-1];
         e = fr[ch][r][c];
         if (avg) begin
            v = (a + b + d + e) >>> 2;
         end else begin
            v = a;
            if (b > v) v = b;
            if (d > v) v = d;
            if (e > v) v = e;
         end
`ifdef SAMPLING_RELU_EN
         if (v < 0) v = 0;
`endif
         res[ch*W +: W] = v[W-1:0];
      end
      return res;
   endfunction

   task automatic drive(input bit v, input bit f, input int p0,
                        input int p1);
      @(negedge clk);
      vld = v;
      fin = f;
      pix = {16'(p1), 16'(p0)};
      if (f) begin
         if (mrow != 0 || mcol != 0) begin
            while (qm.size() != 0 && qm[$].t > cyc) void'(qm.pop_back());
            while (qa.size() != 0 && qa[$].t > cyc) void'(qa.pop_back());
         end
         mrow = 0;
         mcol = 0;
      end else if (v) begin
         fr[0][mrow][mcol] = p0;
         fr[1][mrow][mcol] = p1;
         if ((mrow % 2) == 1 && (mcol % 2) == 1) begin
            bit last;
            last = (mrow == IH-1) && (mcol == IW-1);
            qm.push_back('{expv(0, mrow, mcol), last, cyc + 2});
            qa.push_back('{expv(1, mrow, mcol), last, cyc + 2});
         end
         if (mcol == IW-1) begin
            mcol = 0;
            mrow = (mrow == IH-1) ? 0 : mrow + 1;
         end else begin
            mcol++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0);
   endtask

   // kind 0: ramp k / 100+k; kind 1: negative window in top-left.
   task automatic frame(input int kind, input bit gaps, input int npx);
      for (int k = 0; k < npx; k++) begin
         int p0;
         int p1;
         if (gaps && $urandom_range(0, 2) == 0)
            idle($urandom_range(1, 3));
         if (kind == 0) begin
            p0 = k;
            p1 = 100 + k;
         end else begin
            case (k)
               0:       p0 = -1;
               1:       p0 = -2;
               4:       p0 = -3;
               5:       p0 = -4;
               default: p0 = 0;
            endcase
            p1 = -p0 - 7;
         end
         drive(1, 0, p0, p1);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (vm) begin
            nvm++;
            if (fm) nfm++;
            check("max_queued", qm.size() != 0, 1);
            if (qm.size() != 0) begin
               exp_t e;
               e = qm.pop_front();
               check("max_px", om, e.px);
               check("max_fin", fm, e.f);
               check("max_lat", cyc, e.t);
            end
         end else begin
            check("max_fin_alone", fm, 0);
         end
         if (va) begin
            nva++;
            if (fa) nfa++;
            check("avg_queued", qa.size() != 0, 1);
            if (qa.size() != 0) begin
               exp_t e;
               e = qa.pop_front();
               check("avg_px", oa, e.px);
               check("avg_fin", fa, e.f);
               check("avg_lat", cyc, e.t);
            end
         end
      end
   end

   initial begin
      int v0;
      int f0;
      int a0;
      rst_n = 1'b0;
      vld   = 1'b0;
      fin   = 1'b0;
      pix   = '0;
      repeat (3) @(negedge clk);
      check("rst_vm", vm, 0);
      check("rst_fm", fm, 0);
      check("rst_om", om, 0);
      check("rst_oa", oa, 0);
      rst_n = 1'b1;
      idle(2);

      v0 = nvm; f0 = nfm; a0 = nva;
      frame(0, 0, IW*IH);
      idle(4);
      check("t1_nvalid", nvm - v0, 4);
      check("t1_nfinish", nfm - f0, 1);
      check("t2_avg_nvalid", nva - a0, 4);

      v0 = nvm; f0 = nfm;
      frame(1, 0, IW*IH);
      idle(4);
      check("t3_nvalid", nvm - v0, 4);

      v0 = nvm; f0 = nfm;
      frame(0, 1, IW*IH);
      idle(4);
      check("t4_nvalid", nvm - v0, 4);
      check("t4_nfinish", nfm - f0, 1);

      v0 = nvm; f0 = nfm;
      frame(0, 0, 6);
      drive(0, 1, 55, 66);
      frame(0, 0, IW*IH);
      idle(4);
      check("t5_nvalid", nvm - v0, 4);
      check("t5_nfinish", nfm - f0, 1);

      frame(1, 0, 7);
      idle(3);
      @(negedge clk);
      rst_n = 1'b0;
      qm.delete();
      qa.delete();
      mrow = 0;
      mcol = 0;
      @(negedge clk);
      check("t6_rst_vm", vm, 0);
      check("t6_rst_om", om, 0);
      check("t6_rst_oa", oa, 0);
      @(negedge clk);
      rst_n = 1'b1;
      v0 = nvm; f0 = nfm; a0 = nva;
      frame(0, 0, IW*IH);
      frame(1, 0, IW*IH);
      idle(4);
      check("t6_nvalid", nvm - v0, 8);
      check("t6_nfinish", nfm - f0, 2);
      check("t6_avg_nvalid", nva - a0, 8);

      check("qm_drained", qm.size(), 0);
      check("qa_drained", qa.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
